ofifo_col_sync: RTL and testbench
=================================

// Module: ofifo_col_sync
// PURPOSE
//  Output buffer on the south edge of the systolic MAC array. Captures per-column psums as each
//  column's valid fires (columns arrive skewed by one cycle each) and re-aligns them into one
//  full-width row word. Downstream (SFU / psum SRAM writer) pops complete rows via rd.
// PARAMETERS
//  col      8   number of array columns / column FIFOs
//  psum_bw  16  psum width per column
//  depth    8   entries per column FIFO; power of 2, >= 2
// PORTS
//  clk       in   1            clock
//  reset     in   1            synchronous, active-high reset
//  in        in   col*psum_bw  psums from array south edge; column c at [(c+1)*psum_bw-1 : c*psum_bw]
//  wr        in   col          per-column write strobe (array valid bus), bit c for column c
//  rd        in   1            pop one aligned row
//  out       out  col*psum_bw  registered row word, same column packing as in
//  o_vld     out  1            out holds a freshly popped row this cycle
//  o_valid   out  1            every column FIFO non-empty (rd will be honoured)
//  o_full    out  1            at least one column FIFO full
//  o_empty   out  1            all column FIFOs empty
// BEHAVIOUR
//  - Reset: all rd/wr pointers 0; out=0, o_vld=0, o_valid=0, o_full=0, o_empty=1. Reset mid-operation
//    discards all buffered data; no write or pop occurs in the reset cycle.
//  - Pointers: log2(depth)+1 bits; index = low bits, wrap bit distinguishes full from empty.
//    Column c full when wr_ptr^rd_ptr == {1'b1, 0...}; empty when equal.
//  - Write: column c writes in slice into entry wr_ptr[c] when wr[c] && (!full[c] || pop); columns
//    independent, any subset may write in one cycle. Write to a full column with no pop is dropped;
//    its pointer does not move.
//  - Pop: pop = rd && o_valid. All col read pointers advance together. rd while !o_valid ignored.
//  - Output latency 1: cycle N pop -> cycle N+1 out = head entries of all columns, o_vld=1.
//    Without pop, out holds last value, o_vld=0.
//  - Simultaneous pop and write on a full column: both accepted, column stays full.
//  - Simultaneous pop and write on a column holding 1 entry: pop returns old head; new entry retained.
//  - o_valid/o_full/o_empty are combinational from current pointers (reflect state after last edge).
//  - No arithmetic on data; psums pass bit-exact, no sign handling.
// CONFIGURATION
//  OFIFO_DROP_CNT_EN defined: extra output port drop_cnt (16 bits) counts dropped column writes
//    (sum over columns per cycle, saturates at 16'hFFFF, cleared by reset).
//  Not defined: port absent, drops silent; all other behaviour identical.
// STRUCTURE
//  - Shared package ofifo_pkg: OFIFO_DEPTH default, OFIFO_PTR_W = $clog2(depth)+1, drop-counter width.
//  - One sub-module: ofifo_col_fifo (single-column FIFO: storage, pointers, full/empty, wr/pop),
//    instantiated col times in a generate loop; top holds pop logic, flag reduction, out register,
//    optional drop counter.
// TESTING
//  1 Skewed fill: wr=8'h01,03,07..FF over 8 cycles, column c data = 16'h0100*c + row -> o_valid
//    rises only after column 7 written; rd -> next cycle out = row-0 word, o_vld=1.
//  2 Full: 8 aligned rows written (wr=8'hFF), no rd -> o_full=1; 9th write dropped; pops return
//    rows 0..7 in order, o_empty=1 after 8th pop (drop_cnt=8 with OFIFO_DROP_CNT_EN).
//  3 Simultaneous: full FIFO, wr=8'hFF + rd same cycle -> o_full stays 1, row 0 out, new row last.
//  4 Early rd: only columns 0-6 written, rd=1 -> no pop, o_vld=0, pointers unchanged.
//  5 Wrap: 3 x depth write/pop cycles with data 16'hA5A5 ^ index -> bit-exact order, no flag glitch.
//  6 Reset mid-fill (4 rows buffered) -> next cycle o_empty=1, o_valid=0, out=0; later rows start at entry 0.

Source files
------------

// File: rtl/ofifo_pkg.sv
// rtl/ofifo_pkg.sv - shared constants and helpers for the column-sync output FIFO
package ofifo_pkg;

  // Default entries per column FIFO (power of 2, >= 2)
  localparam int OFIFO_DEPTH = 8;

  // Pointer width: index bits plus one wrap bit
  function automatic int ofifo_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int OFIFO_PTR_W  = ofifo_ptr_w(OFIFO_DEPTH);

  // Width of the optional dropped-write counter
  localparam int OFIFO_DROP_W = 16;

endpackage

// File: rtl/ofifo_col_fifo.sv
// rtl/ofifo_col_fifo.sv - single-column psum FIFO with wrap-bit full/empty detection
module ofifo_col_fifo
  import ofifo_pkg::*;
#(
  parameter int psum_bw = 16,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [psum_bw-1:0] i_data,
  input  logic               i_wr,
  input  logic               i_pop,
  output logic [psum_bw-1:0] o_head,
  output logic               o_full,
  output logic               o_empty
);

  localparam int PTR_W = ofifo_ptr_w(depth);
  localparam logic [PTR_W-1:0] FULL_XOR = PTR_W'(1) << (PTR_W - 1);

  logic [psum_bw-1:0] r_mem [depth];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic               w_wr_ok;

  assign o_full  = ((r_wr_ptr ^ r_rd_ptr) == FULL_XOR);
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  // A pop in the same cycle frees the head slot, so a full column may still accept
  assign w_wr_ok = i_wr && (!o_full || i_pop);
  assign o_head  = r_mem[r_rd_ptr[PTR_W-2:0]];

  // Pointer update: write and pop advance independently; reset discards contents
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (i_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
    end
  end

  // Storage write into the slot addressed by the write pointer
  always_ff @(posedge clk) begin
    if (!reset && w_wr_ok) r_mem[r_wr_ptr[PTR_W-2:0]] <= i_data;
  end

endmodule

// File: rtl/ofifo_col_sync.sv
// rtl/ofifo_col_sync.sv - systolic south-edge output buffer re-aligning skewed columns; option OFIFO_DROP_CNT_EN
module ofifo_col_sync
  import ofifo_pkg::*;
#(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = OFIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_vld,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_empty
`ifdef OFIFO_DROP_CNT_EN
  ,
  output logic [OFIFO_DROP_W-1:0] drop_cnt
`endif
);

  logic [col-1:0]         w_full;
  logic [col-1:0]         w_empty;
  logic [col*psum_bw-1:0] w_head;
  logic                   w_pop;
  logic [col*psum_bw-1:0] r_out;
  logic                   r_vld;

  for (genvar c = 0; c < col; c++) begin : g_col
    ofifo_col_fifo #(
      .psum_bw(psum_bw),
      .depth  (depth)
    ) u_fifo (
      .clk    (clk),
      .reset  (reset),
      .i_data (in[c*psum_bw +: psum_bw]),
      .i_wr   (wr[c]),
      .i_pop  (w_pop),
      .o_head (w_head[c*psum_bw +: psum_bw]),
      .o_full (w_full[c]),
      .o_empty(w_empty[c])
    );
  end

  // A row is only complete once every column holds an entry; all columns pop together
  assign o_valid = ~|w_empty;
  assign o_full  = |w_full;
  assign o_empty = &w_empty;
  assign w_pop   = rd && o_valid;
  assign out     = r_out;
  assign o_vld   = r_vld;

  // Row register: capture aligned heads on a pop, otherwise hold the last row
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
      r_vld <= 1'b0;
    end else begin
      r_vld <= w_pop;
      if (w_pop) r_out <= w_head;
    end
  end

`ifdef OFIFO_DROP_CNT_EN
  logic [col-1:0]          w_drop;
  logic [OFIFO_DROP_W:0]   w_drop_next;
  logic [OFIFO_DROP_W-1:0] r_drop_cnt;

  assign w_drop   = wr & w_full & {col{~w_pop}};
  assign drop_cnt = r_drop_cnt;

  // Sum this cycle's dropped column writes onto the count with one spare carry bit
  always_comb begin
    w_drop_next = {1'b0, r_drop_cnt};
    for (int c = 0; c < col; c++) begin
      w_drop_next = w_drop_next + (OFIFO_DROP_W+1)'(w_drop[c]);
    end
  end

  // Saturating drop counter
  always_ff @(posedge clk) begin
    if (reset) r_drop_cnt <= '0;
    else       r_drop_cnt <= w_drop_next[OFIFO_DROP_W] ? '1 : w_drop_next[OFIFO_DROP_W-1:0];
  end
`endif

endmodule

// File: tb/tb_ofifo_col_sync.sv
// tb/tb_ofifo_col_sync.sv - directed self-checking bench for ofifo_col_sync; honours OFIFO_DROP_CNT_EN
module tb_ofifo_col_sync;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] in_bus;
  logic [7:0]   wr;
  logic         rd;
  logic [127:0] out_bus;
  logic         o_vld, o_valid, o_full, o_empty;
`ifdef OFIFO_DROP_CNT_EN
  logic [15:0]  drop_cnt;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ofifo_col_sync #(.col(8), .psum_bw(16), .depth(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .in     (in_bus),
    .wr     (wr),
    .rd     (rd),
    .out    (out_bus),
    .o_vld  (o_vld),
    .o_valid(o_valid),
    .o_full (o_full),
    .o_empty(o_empty)
`ifdef OFIFO_DROP_CNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; wr = '0; rd = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Column c of aligned row r holds 16'h0100*c + r
  function automatic logic [127:0] row_word(input int row);
    logic [127:0] w;
    for (int c = 0; c < 8; c++) w[c*16 +: 16] = 16'(256*c + row);
    return w;
  endfunction

  function automatic logic [127:0] wrap_word(input int i);
    logic [127:0] w;
    for (int c = 0; c < 8; c++) w[c*16 +: 16] = 16'hA5A5 ^ 16'(i);
    return w;
  endfunction

  initial begin
    reset = 1'b1; wr = '0; rd = 1'b0; in_bus = '0;
    tick(); tick();
    chk("rst_empty", o_empty, 1'b1);
    chk("rst_valid", o_valid, 1'b0);
    chk("rst_full",  o_full,  1'b0);
    chk("rst_vld",   o_vld,   1'b0);
    chk("rst_out",   out_bus, '0);
    reset = 1'b0;

    // 1: skewed fill, column c gets its row (k-c) at step k
    for (int k = 0; k < 8; k++) begin
      wr = 8'((1 << (k + 1)) - 1);
      for (int c = 0; c < 8; c++) in_bus[c*16 +: 16] = (c <= k) ? 16'(256*c + (k - c)) : 16'h0;
      tick();
      if (k == 6) chk("skew_valid_early", o_valid, 1'b0);
    end
    wr = '0;
    chk("skew_valid", o_valid, 1'b1);
    rd = 1'b1; tick(); rd = 1'b0;
    chk("skew_out", out_bus, row_word(0));
    chk("skew_vld", o_vld, 1'b1);
    tick();
    chk("skew_vld_drop", o_vld, 1'b0);
    chk("skew_out_hold", out_bus, row_word(0));

    // 2: fill to full, drop a ninth row, drain in order
    do_reset();
    for (int r = 0; r < 8; r++) begin
      in_bus = row_word(r); wr = 8'hFF; tick();
    end
    chk("full_flag", o_full, 1'b1);
    in_bus = row_word(8); wr = 8'hFF; tick(); wr = '0;
    chk("full_after_drop", o_full, 1'b1);
`ifdef OFIFO_DROP_CNT_EN
    chk("drop_cnt", drop_cnt, 16'd8);
`endif
    rd = 1'b1;
    for (int r = 0; r < 8; r++) begin
      tick();
      chk($sformatf("drain_out%0d", r), out_bus, row_word(r));
      chk($sformatf("drain_vld%0d", r), o_vld, 1'b1);
    end
    chk("drain_empty", o_empty, 1'b1);
    chk("drain_valid", o_valid, 1'b0);
    tick(); rd = 1'b0;
    chk("empty_rd_vld", o_vld, 1'b0);
    chk("empty_rd_out", out_bus, row_word(7));

    // 3: simultaneous write and pop on a full FIFO
    do_reset();
    for (int r = 0; r < 8; r++) begin
      in_bus = row_word(r); wr = 8'hFF; tick();
    end
    in_bus = row_word(8); wr = 8'hFF; rd = 1'b1; tick(); wr = '0;
    chk("sim_full", o_full, 1'b1);
    chk("sim_out0", out_bus, row_word(0));
    chk("sim_vld",  o_vld, 1'b1);
    for (int r = 1; r < 9; r++) begin
      tick();
      chk($sformatf("sim_out%0d", r), out_bus, row_word(r));
    end
    rd = 1'b0;
    chk("sim_empty", o_empty, 1'b1);
`ifdef OFIFO_DROP_CNT_EN
    chk("sim_drop_cnt", drop_cnt, 16'd0);
`endif

    // 4: rd before the last column arrives is ignored
    do_reset();
    in_bus = row_word(0); wr = 8'h7F; tick(); wr = '0;
    rd = 1'b1; tick(); rd = 1'b0;
    chk("early_vld",   o_vld, 1'b0);
    chk("early_out",   out_bus, '0);
    chk("early_valid", o_valid, 1'b0);
    chk("early_empty", o_empty, 1'b0);
    wr = 8'h80; tick(); wr = '0;
    chk("early_valid_late", o_valid, 1'b1);
    rd = 1'b1; tick(); rd = 1'b0;
    chk("early_out_late", out_bus, row_word(0));
    chk("early_empty_late", o_empty, 1'b1);

    // 5: pointer wrap over three FIFO depths
    for (int i = 0; i < 24; i++) begin
      in_bus = wrap_word(i); wr = 8'hFF; tick(); wr = '0;
      chk($sformatf("wrap_valid%0d", i), o_valid, 1'b1);
      chk($sformatf("wrap_full%0d", i), o_full, 1'b0);
      rd = 1'b1; tick(); rd = 1'b0;
      chk($sformatf("wrap_out%0d", i), out_bus, wrap_word(i));
      chk($sformatf("wrap_empty%0d", i), o_empty, 1'b1);
    end

    // 6: reset with four rows buffered
    do_reset();
    for (int r = 0; r < 4; r++) begin
      in_bus = row_word(r + 16); wr = 8'hFF; tick();
    end
    wr = '0; rd = 1'b1; tick(); rd = 1'b0;
    chk("mid_out_pre", out_bus, row_word(16));
    chk("mid_empty_pre", o_empty, 1'b0);
    reset = 1'b1; in_bus = row_word(9); wr = 8'hFF; rd = 1'b1; tick();
    reset = 1'b0; wr = '0; rd = 1'b0;
    chk("mid_empty", o_empty, 1'b1);
    chk("mid_valid", o_valid, 1'b0);
    chk("mid_full",  o_full,  1'b0);
    chk("mid_out",   out_bus, '0);
    chk("mid_vld",   o_vld,   1'b0);
    in_bus = row_word(5); wr = 8'hFF; tick(); wr = '0;
    rd = 1'b1; tick(); rd = 1'b0;
    chk("mid_restart_out", out_bus, row_word(5));
    chk("mid_restart_empty", o_empty, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
